sysmon_packet_rx: RTL and testbench

UART receiver and packet parser for the sysmon telemetry stream. Packet format is [0x1A][TEMP_H][TEMP_L][VCC_H][VCC_L][ALARM], 8N1, LSB first. The block sits on the host-side or loopback-test end of the link. It recovers bytes from the serial line, frames packets by header, and presents the last good temperature/VccInt/alarm sample with a valid pulse.

---
 rtl/sysmon_packet_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sysmon_packet_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysmon_packet_rx.sv
// sysmon_packet_rx: UART 8N1 receiver and packet parser for the sysmon
// telemetry stream [0x1A][TEMP_H][TEMP_L][VCC_H][VCC_L][ALARM].
// The last good sample is presented on temp/vcc/alarm together with a
// one-cycle pkt_valid pulse.
// Optional build macro: SYSMON_RX_TIMEOUT_EN (inter-byte watchdog in COLLECT).
module sysmon_packet_rx #(
  parameter int unsigned CLK_FREQ      = 20000000,
  parameter int unsigned BAUD_RATE     = 125000,
  parameter int unsigned TIMEOUT_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  output logic [15:0] temp,
  output logic [15:0] vcc,
  output logic        alarm,
  output logic        pkt_valid,
  output logic        frame_err,
  output logic        pkt_err,
  output logic [15:0] pkt_count
);

  localparam int unsigned BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_PERIOD - 1);

  localparam logic [7:0] HEADER = 8'h1A;

  // Byte FSM states
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  // Parser states
  localparam logic [0:0] P_HUNT    = 1'b0;
  localparam logic [0:0] P_COLLECT = 1'b1;

  if (BIT_PERIOD < 4) begin : g_bad_bit_period
    $error("sysmon_packet_rx: BIT_PERIOD = CLK_FREQ/BAUD_RATE must be >= 4");
  end

  if (TIMEOUT_BYTES < 1) begin : g_bad_timeout
    $error("sysmon_packet_rx: TIMEOUT_BYTES must be >= 1");
  end

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  logic             w_bit_end;
  logic             w_byte_done;
  logic             w_frame_evt;

  logic [0:0]       r_pstate;
  logic [2:0]       r_idx;
  logic [15:0]      r_sh_temp;
  logic [15:0]      r_sh_vcc;

  logic [15:0]      r_temp;
  logic [15:0]      r_vcc;
  logic             r_alarm;
  logic             r_pkt_valid;
  logic             r_frame_err;
  logic             r_pkt_err;
  logic [15:0]      r_pkt_count;

`ifdef SYSMON_RX_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = TIMEOUT_BYTES * 10 * BIT_PERIOD;
  localparam int unsigned WD_W      = $clog2(TO_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TO_CYCLES - 1);

  logic [WD_W-1:0]  r_wdog;
  logic             w_timeout;
`endif

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx        = r_sync2;
  assign w_bit_end   = (r_cnt == CNT_BIT_END);
  // Stop-bit sample point: good stop completes the byte, low stop is a framing error
  assign w_byte_done = (r_state == RX_STOP) && w_bit_end &&  w_rx;
  assign w_frame_evt = (r_state == RX_STOP) && w_bit_end && !w_rx;

  // Byte FSM: start-bit qualification at mid-bit, then one sample per bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) begin
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_cnt == CNT_HALF_END) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_BREAK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_BREAK: begin
          r_cnt <= '0;
          if (w_rx) begin
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state <= RX_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Framing error pulse, aligned with the pkt_err it may cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_evt;
    end
  end

`ifdef SYSMON_RX_TIMEOUT_EN
  assign w_timeout = (r_pstate == P_COLLECT) && !w_byte_done && !w_frame_evt &&
                     (r_wdog == WD_END);

  // Watchdog: cycles since the last byte while collecting a payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if ((r_pstate == P_HUNT) || w_byte_done) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end
`endif

  // Packet parser: header hunt, payload shadowing, atomic output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate    <= P_HUNT;
      r_idx       <= '0;
      r_sh_temp   <= '0;
      r_sh_vcc    <= '0;
      r_temp      <= '0;
      r_vcc       <= '0;
      r_alarm     <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
      case (r_pstate)
        P_HUNT: begin
          r_idx <= '0;
          if (w_byte_done && (r_shift == HEADER)) begin
            r_pstate <= P_COLLECT;
          end
        end
        P_COLLECT: begin
          if (w_frame_evt) begin
            r_pkt_err <= 1'b1;
            r_pstate  <= P_HUNT;
          end else if (w_byte_done) begin
            // A 0x1A here is payload data; only HUNT looks for the header
            case (r_idx)
              3'd0: r_sh_temp[15:8] <= r_shift;
              3'd1: r_sh_temp[7:0]  <= r_shift;
              3'd2: r_sh_vcc[15:8]  <= r_shift;
              3'd3: r_sh_vcc[7:0]   <= r_shift;
              default: begin
                if (r_shift[7:1] == 7'd0) begin
                  r_temp      <= r_sh_temp;
                  r_vcc       <= r_sh_vcc;
                  r_alarm     <= r_shift[0];
                  r_pkt_valid <= 1'b1;
                  r_pkt_count <= r_pkt_count + 16'd1;
                end else begin
                  r_pkt_err <= 1'b1;
                end
                r_pstate <= P_HUNT;
              end
            endcase
            r_idx <= r_idx + 3'd1;
          end
`ifdef SYSMON_RX_TIMEOUT_EN
          else if (w_timeout) begin
            r_pkt_err <= 1'b1;
            r_sh_temp <= '0;
            r_sh_vcc  <= '0;
            r_pstate  <= P_HUNT;
          end
`endif
        end
        default: begin
          r_pstate <= P_HUNT;
        end
      endcase
    end
  end

  assign temp      = r_temp;
  assign vcc       = r_vcc;
  assign alarm     = r_alarm;
  assign pkt_valid = r_pkt_valid;
  assign frame_err = r_frame_err;
  assign pkt_err   = r_pkt_err;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_sysmon_packet_rx.sv
// tb_sysmon_packet_rx: directed bench for sysmon_packet_rx at default
// parameters (BIT_PERIOD = 160). Pulses are tallied on the falling edge.
module tb_sysmon_packet_rx;

  localparam int BP = 160;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [15:0] temp;
  logic [15:0] vcc;
  logic        alarm;
  logic        pkt_valid;
  logic        frame_err;
  logic        pkt_err;
  logic [15:0] pkt_count;

  int total = 0;
  int bad   = 0;

  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  int n_both  = 0;
  int s_valid, s_ferr, s_perr, s_both;

  sysmon_packet_rx #(
    .CLK_FREQ     (20000000),
    .BAUD_RATE    (125000),
    .TIMEOUT_BYTES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .temp     (temp),
    .vcc      (vcc),
    .alarm    (alarm),
    .pkt_valid(pkt_valid),
    .frame_err(frame_err),
    .pkt_err  (pkt_err),
    .pkt_count(pkt_count)
  );

  always #25 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_ferr++;
    if (pkt_err === 1'b1) n_perr++;
    if (frame_err === 1'b1 && pkt_err === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_valid = n_valid;
    s_ferr  = n_ferr;
    s_perr  = n_perr;
    s_both  = n_both;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_low);
    rx_in = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (BP) @(negedge clk);
    end
    rx_in = stop_low ? 1'b0 : 1'b1;
    repeat (BP) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic send_pkt(input logic [47:0] p);
    for (int i = 5; i >= 0; i--) begin
      logic [47:0] w;
      w = p >> (8 * i);
      send_byte(w[7:0], 1'b0);
    end
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_temp", 32'(temp), 32'h0);
    check("rst_vcc", 32'(vcc), 32'h0);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_count", 32'(pkt_count), 32'h0);
    check("rst_pulses", {29'd0, pkt_valid, frame_err, pkt_err}, 32'h0);
    rst_n = 1'b1;

    // 1: first packet after long idle
    idle(1000);
    snap();
    send_pkt(48'h1A_0B_2C_9D_40_01);
    idle(20);
    check("t1_valid", 32'(n_valid - s_valid), 32'd1);
    check("t1_temp", 32'(temp), 32'h0B2C);
    check("t1_vcc", 32'(vcc), 32'h9D40);
    check("t1_alarm", 32'(alarm), 32'h1);
    check("t1_count", 32'(pkt_count), 32'd1);
    check("t1_ferr", 32'(n_ferr - s_ferr), 32'd0);
    check("t1_perr", 32'(n_perr - s_perr), 32'd0);

    // 2: junk bytes before header are ignored
    snap();
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_pkt(48'h1A_12_34_56_78_00);
    idle(20);
    check("t2_valid", 32'(n_valid - s_valid), 32'd1);
    check("t2_temp", 32'(temp), 32'h1234);
    check("t2_vcc", 32'(vcc), 32'h5678);
    check("t2_alarm", 32'(alarm), 32'h0);
    check("t2_count", 32'(pkt_count), 32'd2);
    check("t2_perr", 32'(n_perr - s_perr), 32'd0);

    // 3: framing error inside payload aborts the packet
    snap();
    send_byte(8'h1A, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    idle(200);
    check("t3_ferr", 32'(n_ferr - s_ferr), 32'd1);
    check("t3_perr", 32'(n_perr - s_perr), 32'd1);
    check("t3_same_cycle", 32'(n_both - s_both), 32'd1);
    check("t3_no_valid", 32'(n_valid - s_valid), 32'd0);
    check("t3_temp_hold", 32'(temp), 32'h1234);
    check("t3_vcc_hold", 32'(vcc), 32'h5678);
    check("t3_count_hold", 32'(pkt_count), 32'd2);
    snap();
    send_pkt(48'h1A_AB_CD_EF_01_00);
    idle(20);
    check("t3b_valid", 32'(n_valid - s_valid), 32'd1);
    check("t3b_temp", 32'(temp), 32'hABCD);
    check("t3b_vcc", 32'(vcc), 32'hEF01);
    check("t3b_count", 32'(pkt_count), 32'd3);

    // 4: illegal ALARM byte
    snap();
    send_pkt(48'h1A_00_01_00_02_03);
    idle(20);
    check("t4_perr", 32'(n_perr - s_perr), 32'd1);
    check("t4_no_valid", 32'(n_valid - s_valid), 32'd0);
    check("t4_count", 32'(pkt_count), 32'd3);
    check("t4_temp_hold", 32'(temp), 32'hABCD);
    check("t4_alarm_hold", 32'(alarm), 32'h0);

    // 5: short low glitch is a false start; 0x1A in payload is data
    snap();
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    idle(400);
    check("t5_glitch_ferr", 32'(n_ferr - s_ferr), 32'd0);
    check("t5_glitch_perr", 32'(n_perr - s_perr), 32'd0);
    check("t5_glitch_valid", 32'(n_valid - s_valid), 32'd0);
    snap();
    send_pkt(48'h1A_1A_00_00_00_00);
    idle(20);
    check("t5_valid", 32'(n_valid - s_valid), 32'd1);
    check("t5_temp", 32'(temp), 32'h1A00);
    check("t5_vcc", 32'(vcc), 32'h0000);
    check("t5_count", 32'(pkt_count), 32'd4);

    // 6: stalled packet, then reset in the middle of a byte
    snap();
    send_byte(8'h1A, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    idle(3300);
`ifdef SYSMON_RX_TIMEOUT_EN
    check("t6_timeout_perr", 32'(n_perr - s_perr), 32'd1);
`else
    check("t6_no_timeout_perr", 32'(n_perr - s_perr), 32'd0);
`endif
    check("t6_stall_valid", 32'(n_valid - s_valid), 32'd0);
    check("t6_stall_count", 32'(pkt_count), 32'd4);
    rx_in = 1'b0;
    repeat (BP + BP / 2) @(negedge clk);
    rx_in = 1'b1;
    repeat (BP) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rst_temp", 32'(temp), 32'h0);
    check("t6_rst_vcc", 32'(vcc), 32'h0);
    check("t6_rst_alarm", 32'(alarm), 32'h0);
    check("t6_rst_count", 32'(pkt_count), 32'h0);
    check("t6_rst_pulses", {29'd0, pkt_valid, frame_err, pkt_err}, 32'h0);
    rst_n = 1'b1;
    idle(200);
    snap();
    send_byte(8'h77, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(20);
    check("t6_no_stale_valid", 32'(n_valid - s_valid), 32'd0);
    check("t6_no_stale_perr", 32'(n_perr - s_perr), 32'd0);
    snap();
    send_pkt(48'h1A_5A_A5_3C_C3_01);
    idle(20);
    check("t6_valid", 32'(n_valid - s_valid), 32'd1);
    check("t6_temp", 32'(temp), 32'h5AA5);
    check("t6_vcc", 32'(vcc), 32'h3CC3);
    check("t6_alarm", 32'(alarm), 32'h1);
    check("t6_count", 32'(pkt_count), 32'd1);
    check("t6_errs", 32'((n_perr - s_perr) + (n_ferr - s_ferr)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
